// File: rtl/cla_pkg.sv
// cla_pkg: shared types and configuration check for the pipelined CLA adder.
package cla_pkg;
  localparam int CLA_MAX_W = 64;
  typedef enum logic { OP_ADD = 1'b0, OP_SUB = 1'b1 } op_e;
  // Operands travel at full width; stage k consumes and fills segment k only.
  typedef struct packed {
    logic valid;
    op_e op;
    logic carry;
    logic [CLA_MAX_W-1:0] a;
    logic [CLA_MAX_W-1:0] b;
    logic [CLA_MAX_W-1:0] sum;
  } stage_t;
  function automatic bit cla_cfg_ok(input int dw, input int ns);
    return ns >= 1 && dw >= 1 && dw <= CLA_MAX_W && (dw % ns) == 0;
  endfunction
endpackage

// File: rtl/cla_segment.sv
// cla_segment: W-bit carry-lookahead slice built from group generate/propagate terms.
module cla_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0] c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  always_comb begin
    logic gg;
    logic pp;
    gg = 1'b0;
    pp = 1'b1;
    c[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      gg = g[i] | (p[i] & gg);
      pp = pp & p[i];
      c[i+1] = gg | (pp & cin_i);
    end
  end
  assign sum_o = p ^ c[W-1:0];
  assign cout_o = c[W];
endmodule

// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: segmented pipelined CLA add/subtract with valid/ready and a global stall.
// Optional PIPE_CLA_OVF_EN adds a signed-overflow output o_overflow.
module pipe_cla_adder
  import cla_pkg::*;
#(
  parameter int DATA_WIDTH = 17,
  parameter int NUM_STAGES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data_one,
  input  logic [DATA_WIDTH-1:0] i_data_two,
  input  logic                  i_sub,
  input  logic                  i_cin,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
`ifdef PIPE_CLA_OVF_EN
  output logic                  o_overflow,
`endif
  output logic                  o_carry
);
  localparam int SEG_WIDTH = DATA_WIDTH / (NUM_STAGES < 1 ? 1 : NUM_STAGES);
  if (!cla_cfg_ok(DATA_WIDTH, NUM_STAGES)) begin : g_bad_cfg
    $error("pipe_cla_adder: DATA_WIDTH must be a multiple of NUM_STAGES (>=1) and <= CLA_MAX_W");
  end
  logic adv;
  stage_t last;
  logic unused_bits;
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    stage_t cur;
    stage_t st_d;
    stage_t st_q;
    logic [SEG_WIDTH-1:0] s;
    logic c;
    if (k == 0) begin : g_head
      // Subtraction enters as A + ~B + !cin; the inversion of B happens per segment.
      always_comb begin
        cur = '0;
        cur.valid = i_valid;
        cur.op = op_e'(i_sub);
        cur.carry = i_cin ^ i_sub;
        cur.a = CLA_MAX_W'(i_data_one);
        cur.b = CLA_MAX_W'(i_data_two);
      end
    end else begin : g_body
      assign cur = g_stage[k-1].st_q;
    end
    cla_segment #(.W(SEG_WIDTH)) u_seg (
      .a_i(cur.a[k*SEG_WIDTH +: SEG_WIDTH]),
      .b_i(cur.b[k*SEG_WIDTH +: SEG_WIDTH] ^ {SEG_WIDTH{cur.op == OP_SUB}}),
      .cin_i(cur.carry),
      .sum_o(s),
      .cout_o(c)
    );
    always_comb begin
      st_d = cur;
      st_d.sum[k*SEG_WIDTH +: SEG_WIDTH] = s;
      st_d.carry = c;
    end
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) st_q <= '0;
      else if (adv) st_q <= st_d;
  end
  assign last = g_stage[NUM_STAGES-1].st_q;
  assign adv = !last.valid || i_ready;
  assign o_ready = adv;
  assign o_valid = last.valid;
  assign o_data = last.sum[DATA_WIDTH-1:0];
  assign o_carry = last.carry;
`ifdef PIPE_CLA_OVF_EN
  assign o_overflow = (last.a[DATA_WIDTH-1] == (last.b[DATA_WIDTH-1] ^ (last.op == OP_SUB)))
                   && (last.sum[DATA_WIDTH-1] != last.a[DATA_WIDTH-1]);
`endif
  assign unused_bits = ^last;
endmodule

// File: tb/tb_pipe_cla_adder.sv
// tb_pipe_cla_adder: randomized and directed checks of pipe_cla_adder against an arithmetic model.
module tb_pipe_cla_adder;
  localparam int DW = 16;
  localparam int NS = 4;
  logic clk = 1'b0;
  logic rst, i_valid, o_ready, i_sub, i_cin, o_valid, i_ready, o_carry;
  logic [DW-1:0] a, b, o_data;
`ifdef PIPE_CLA_OVF_EN
  logic o_overflow;
`endif
  typedef struct { logic [DW-1:0] d; logic c; logic v; int t; } exp_t;
  exp_t q[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_lat = 1'b0;
  always #5 clk = ~clk;

  pipe_cla_adder #(.DATA_WIDTH(DW), .NUM_STAGES(NS)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data_one(a),
    .i_data_two(b),
    .i_sub(i_sub),
    .i_cin(i_cin),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data(o_data),
`ifdef PIPE_CLA_OVF_EN
    .o_overflow(o_overflow),
`endif
    .o_carry(o_carry)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic sub, input logic cin);
    exp_t e;
    int r, s;
    r = sub ? int'(x) - int'(y) - int'(cin) : int'(x) + int'(y) + int'(cin);
    s = sub ? int'($signed(x)) - int'($signed(y)) - int'(cin)
            : int'($signed(x)) + int'($signed(y)) + int'(cin);
    e.d = DW'(r);
    e.c = sub ? (r >= 0) : (r >= 2**DW);
    e.v = (s > 2**(DW-1) - 1) || (s < -(2**(DW-1)));
    e.t = cyc;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    check("ready", o_ready, !o_valid || i_ready);
    if (o_valid) begin
      if (q.size() == 0) check("spurious_valid", o_valid, 1'b0);
      else begin
        check("data", o_data, q[0].d);
        check("carry", o_carry, q[0].c);
`ifdef PIPE_CLA_OVF_EN
        check("overflow", o_overflow, q[0].v);
`endif
        if (i_ready) begin
          if (chk_lat) check("latency", cyc - q[0].t, NS);
          void'(q.pop_front());
        end
      end
    end
    if (i_valid && (!o_valid || i_ready)) q.push_back(model(a, b, i_sub, i_cin));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic op(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic sub, input logic cin);
    a = x; b = y; i_sub = sub; i_cin = cin; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 40 && q.size() != 0; n++) tick();
    check("drain", q.size(), 0);
  endtask

  function automatic logic [DW-1:0] pick();
    logic [DW-1:0] corners [4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : DW'($urandom);
  endfunction

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; a = '0; b = '0; i_sub = 1'b0; i_cin = 1'b0;
    #12;
    check("rst_valid", o_valid, 1'b0);
    check("rst_ready", o_ready, 1'b1);
    check("rst_data", o_data, 0);
    check("rst_carry", o_carry, 1'b0);
`ifdef PIPE_CLA_OVF_EN
    check("rst_ovf", o_overflow, 1'b0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_lat = 1'b1;
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op(16'h0005, 16'h0007, 1'b1, 1'b0);
    op(16'h0007, 16'h0005, 1'b1, 1'b0);
    op(16'h0000, 16'h0000, 1'b1, 1'b1);
    op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
`ifdef PIPE_CLA_OVF_EN
    op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op(16'h0001, 16'h0001, 1'b0, 1'b0);
    op(16'h8000, 16'h0001, 1'b1, 1'b0);
`endif
    drain();
    // back-to-back stream
    for (int n = 0; n < 8; n++) op(pick(), pick(), 1'(n & 1), 1'($urandom));
    drain();
    // stall with a result waiting at the output
    chk_lat = 1'b0;
    op(16'h1234, 16'h4321, 1'b0, 1'b0);
    op(16'h00FF, 16'h0F00, 1'b1, 1'b1);
    i_ready = 1'b0;
    for (int n = 0; n < 10 && !o_valid; n++) tick();
    check("stall_arrive", o_valid, 1'b1);
    a = 16'hAAAA; b = 16'h5555; i_sub = 1'b0; i_cin = 1'b1; i_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      check("stall_ready", o_ready, 1'b0);
      tick();
    end
    i_valid = 1'b0;
    drain();
    // reset with transactions in flight
    chk_lat = 1'b1;
    for (int n = 0; n < 3; n++) op(pick(), pick(), 1'($urandom), 1'($urandom));
    rst = 1'b1;
    #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    check("mid_rst_data", o_data, 0);
    q.delete();
    tick();
    tick();
    rst = 1'b0;
    op(16'hBEEF, 16'h1111, 1'b1, 1'b0);
    drain();
    // randomized traffic with random backpressure
    chk_lat = 1'b0;
    for (int n = 0; n < 400; n++) begin
      a = pick(); b = pick(); i_sub = 1'($urandom); i_cin = 1'($urandom);
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
